// File: rtl/clint_types_1_13_pkg.sv
// Shared constants and types for the machine-level CLINT: register offsets,
// bus state encoding, 64-bit word type and a byte-lane merge helper.
package clint_types_1_13_pkg;

  localparam logic [15:0] CLINT_MSIP        = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
  localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
  localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
  localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

  typedef enum logic {IDLE, RESP} clint_state_t;

  typedef logic [63:0] clint_word_t;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  lanes);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) res[i*8 +: 8] = new_word[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_mtimer.sv
// Machine timer: prescaled 64-bit mtime, mtimecmp storage with byte-lane
// writes, registered compare and falling-edge clear pulse.
module clint_mtimer
  import clint_types_1_13_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mtime_we,
  input  logic [1:0]  cmp_we,
  input  logic [3:0]  byte_en,
  input  logic [31:0] wdata,
  output clint_word_t mtime,
  output clint_word_t mtimecmp,
  output logic        timer_int,
  output logic        clear_timer_int
);

  localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

  logic [15:0] presc;
  logic        cmp_hit;

  assign cmp_hit = (mtime >= mtimecmp);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc           <= '0;
      mtime           <= '0;
      mtimecmp        <= '1;
      timer_int       <= 1'b0;
      clear_timer_int <= 1'b0;
    end else begin
      // A software write to either half wins over the tick and restarts the prescaler.
      if (|mtime_we) begin
        presc <= '0;
        if (mtime_we[0]) mtime[31:0]  <= merge_lanes(mtime[31:0], wdata, byte_en);
        if (mtime_we[1]) mtime[63:32] <= merge_lanes(mtime[63:32], wdata, byte_en);
      end else if (presc == PRESC_LAST) begin
        presc <= '0;
        mtime <= mtime + 64'd1;
      end else begin
        presc <= presc + 16'd1;
      end

      if (cmp_we[0]) mtimecmp[31:0]  <= merge_lanes(mtimecmp[31:0], wdata, byte_en);
      if (cmp_we[1]) mtimecmp[63:32] <= merge_lanes(mtimecmp[63:32], wdata, byte_en);

      timer_int       <= cmp_hit;
      clear_timer_int <= timer_int & ~cmp_hit;
    end
  end

endmodule

// File: rtl/priv_1_13_clint.sv
// Core-local interruptor: word-addressed bus slave with one wait cycle,
// msip register, mtime read shadow, and the machine timer sub-block.
module priv_1_13_clint
  import clint_types_1_13_pkg::*;
#(
  parameter int          PRESCALE  = 1,
  parameter logic [15:0] BASE_MASK = 16'hFFFF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] addr,
  input  logic        ren,
  input  logic        wen,
  input  logic [3:0]  byte_en,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        timer_int_m,
  output logic        soft_int_m,
  output logic        clear_timer_int_m,
  output logic        clear_soft_int_m
);

  clint_state_t state;
  clint_word_t  mtime;
  clint_word_t  mtimecmp;
  logic [15:0]  word_addr;
  logic         accept;
  logic         wr;
  logic         rd_only;
  logic         msip;
  logic [31:0]  shadow;
  logic         last_lo_rd;
  logic [31:0]  rd_mux;
  logic [1:0]   mtime_we;
  logic [1:0]   cmp_we;

  assign word_addr = addr & BASE_MASK & 16'hFFFC;
  assign accept    = (state == IDLE) && (ren || wen);
  assign wr        = accept && wen;
  assign rd_only   = accept && ren && !wen;
  assign busy      = accept;
  assign soft_int_m = msip;

  assign mtime_we = {wr && (word_addr == CLINT_MTIME_HI),    wr && (word_addr == CLINT_MTIME_LO)};
  assign cmp_we   = {wr && (word_addr == CLINT_MTIMECMP_HI), wr && (word_addr == CLINT_MTIMECMP_LO)};

  always_comb begin
    rd_mux = '0;
    case (word_addr)
      CLINT_MSIP:        rd_mux = {31'd0, msip};
      CLINT_MTIMECMP_LO: rd_mux = mtimecmp[31:0];
      CLINT_MTIMECMP_HI: rd_mux = mtimecmp[63:32];
      CLINT_MTIME_LO:    rd_mux = mtime[31:0];
      // Hi half comes from the shadow only right after a lo read, so lo+hi reads form one snapshot.
      CLINT_MTIME_HI:    rd_mux = last_lo_rd ? shadow : mtime[63:32];
      default:           rd_mux = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state            <= IDLE;
      rdata            <= '0;
      msip             <= 1'b0;
      shadow           <= '0;
      last_lo_rd       <= 1'b0;
      clear_soft_int_m <= 1'b0;
    end else begin
      clear_soft_int_m <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= RESP;
            rdata      <= rd_mux;
            last_lo_rd <= rd_only && (word_addr == CLINT_MTIME_LO);
            if (rd_only && (word_addr == CLINT_MTIME_LO)) shadow <= mtime[63:32];
            if (wr && (word_addr == CLINT_MSIP) && byte_en[0]) begin
              msip             <= wdata[0];
              clear_soft_int_m <= msip & ~wdata[0];
            end
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  clint_mtimer #(.PRESCALE(PRESCALE)) u_mtimer (
    .clk             (CLK),
    .rst             (RST),
    .mtime_we        (mtime_we),
    .cmp_we          (cmp_we),
    .byte_en         (byte_en),
    .wdata           (wdata),
    .mtime           (mtime),
    .mtimecmp        (mtimecmp),
    .timer_int       (timer_int_m),
    .clear_timer_int (clear_timer_int_m)
  );

endmodule
